// File: rtl/clmul_dser.sv
// Digit-serial GF(2) word multiplier with XOR accumulation across a chain of operations.
//
// For one operation, P[i] = XOR_j (op_a[W-1-j] & op_b[i+j]) for i, j in 0..W-1. Each BUSY
// cycle folds in one digit of D_W multiplier bits. Digits are taken in ascending j, which means
// from the top of op_a downward. Results of successive operations are XORed together until a
// beat marked in_last. The chain result is then presented on mul_r with a valid/ready handshake.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset; discards any chain in flight
//   in_valid   in   operand beat valid
//   in_ready   out  beat can be accepted (IDLE only, low during reset)
//   in_last    in   this beat closes the accumulation chain
//   op_a       in   multiplier word, G_DAT_W bits
//   op_b       in   multiplicand window, 2*G_DAT_W-1 bits
//   out_valid  out  mul_r holds a completed chain result
//   out_ready  in   consumer accepts the result
//   mul_r      out  registered chain result, G_DAT_W bits
module clmul_dser #(
  parameter int G_DAT_W = 64,
  parameter int D_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [G_DAT_W-1:0]   op_a,
  input  logic [2*G_DAT_W-2:0] op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [G_DAT_W-1:0]   mul_r
);

  localparam int N     = G_DAT_W / D_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((D_W < 1) || (G_DAT_W % D_W != 0)) begin : g_bad_dw
    $error("clmul_dser: D_W must divide G_DAT_W");
  end

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;

  logic [G_DAT_W-1:0]   r_a;
  logic [2*G_DAT_W-2:0] r_b;
  logic                 r_last;
  logic [CNT_W-1:0]     r_cnt;
  logic [G_DAT_W-1:0]   r_acc;
  logic [G_DAT_W-1:0]   r_mul;

  logic [G_DAT_W-1:0]   w_pp;
  logic [G_DAT_W-1:0]   w_acc_nxt;
  logic                 w_cnt_end;

  assign w_cnt_end = (r_cnt == CNT_W'(N - 1));
  assign w_acc_nxt = r_acc ^ w_pp;
  assign mul_r     = r_mul;

  // Partial product of the current digit. r_a is shifted left and r_b right by one digit per
  // BUSY cycle. The current digit's multiplier bits therefore always sit at the top of r_a, and
  // the matching multiplicand window always starts at bit 0 of r_b. This avoids a wide
  // cnt-indexed mux.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < G_DAT_W; i++) begin
      for (int k = 0; k < D_W; k++) begin
        w_pp[i] = w_pp[i] ^ (r_a[G_DAT_W-1-k] & r_b[i+k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = ~rst;
        if (in_valid) begin
          w_state_nxt = StBusy;
        end
      end
      StBusy: begin
        if (w_cnt_end) begin
          w_state_nxt = r_last ? StDone : StIdle;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_last <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_mul  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a    <= op_a;
            r_b    <= op_b;
            r_last <= in_last;
            r_cnt  <= '0;
          end
        end
        StBusy: begin
          r_acc <= w_acc_nxt;
          // The counter wraps freely after the last digit. It is reloaded on the next acceptance.
          r_cnt <= r_cnt + 1'b1;
          r_a   <= r_a << D_W;
          r_b   <= r_b >> D_W;
          if (w_cnt_end && r_last) begin
            r_mul <= w_acc_nxt;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clmul_dser.sv
// Self-checking bench for clmul_dser. Four instances run in parallel with D_W = 1, 8, 16 and 64.
// Each instance gets directed vectors and then random chains. Expected chain results are pushed
// into a per-instance queue as beats are issued. A separate monitor pops the queue whenever the
// DUT raises out_valid and checks both the data and the latency.
module tb_clmul_dser;

  localparam int W   = 64;
  localparam int LIM = 600;

  localparam logic [W-1:0]   A1 = 64'h8000_0000_0000_0000;
  localparam logic [2*W-2:0] B1 = 127'h0123_4567_89AB_CDEF;
  localparam logic [2*W-2:0] B2 = 127'h1 << 63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: the window is bits [2W-2:W-1] of the full carry-less product a*b.
  function automatic logic [W-1:0] model_p(input logic [W-1:0] a, input logic [2*W-2:0] b);
    logic [3*W-1:0] prod;
    prod = '0;
    for (int m = 0; m < W; m++) begin
      if (a[m]) prod = prod ^ ({{(W + 1){1'b0}}, b} << m);
    end
    return prod[2*W-2:W-1];
  endfunction

  function automatic logic [W-1:0] rnd_a();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [2*W-2:0] rnd_b();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[2*W-2:0];
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int DW      = (g == 0) ? 1 : (g == 1) ? 8 : (g == 2) ? 16 : 64;
    localparam int N       = W / DW;
    localparam int RST_OFS = (N >= 3) ? 3 : N;

    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_last;
    logic [W-1:0]   op_a;
    logic [2*W-2:0] op_b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   mul_r;

    logic [W-1:0] exp_q[$];
    int           ecyc_q[$];
    logic [W-1:0] chain = '0;
    int           cyc = 0;
    int           or_mode = 2;  // 0 random out_ready, 1 hold low, 2 hold high
    bit           done = 1'b0;

    clmul_dser #(
      .G_DAT_W(W),
      .D_W    (DW)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_last  (in_last),
      .op_a     (op_a),
      .op_b     (op_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .mul_r    (mul_r)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Issue one beat; returns at 1 time unit after the acceptance edge.
    task automatic send(input logic [W-1:0] a, input logic [2*W-2:0] b, input logic last,
                        input bit track);
      int e;
      int t;
      op_a     = a;
      op_b     = b;
      in_last  = last;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < LIM) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= LIM) check($sformatf("D_W=%0d accept_wait", DW), in_ready, 1'b1);
      @(posedge clk); #1;
      e        = cyc;
      in_valid = 1'b0;
      op_a     = rnd_a();
      op_b     = rnd_b();
      in_last  = $urandom_range(0, 1) != 0;
      if (track) begin
        chain = chain ^ model_p(a, b);
        if (last) begin
          exp_q.push_back(chain);
          ecyc_q.push_back(e);
          chain = '0;
        end
      end
      if (!last) begin
        t = 0;
        while (!in_ready && t < N + 5) begin
          @(posedge clk); #1;
          t++;
        end
        check($sformatf("D_W=%0d ready_latency", DW), cyc - e, N);
      end
    endtask

    task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < LIM) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= LIM) check($sformatf("D_W=%0d %s drain", DW, name), exp_q.size(), 0);
    endtask

    // Monitor: pops an expectation on every rising out_valid and checks that mul_r is held.
    initial begin
      logic [W-1:0] held;
      bit           prev;
      int           ec;
      held      = '0;
      prev      = 1'b0;
      out_ready = 1'b0;
      forever begin
        @(posedge clk); #1;
        if (out_valid && !prev) begin
          if (exp_q.size() == 0) begin
            check($sformatf("D_W=%0d spurious_out_valid", DW), out_valid, 1'b0);
          end else begin
            ec = ecyc_q.pop_front();
            check($sformatf("D_W=%0d mul_r", DW), mul_r, exp_q.pop_front());
            check($sformatf("D_W=%0d out_latency", DW), cyc - ec, N);
          end
          held = mul_r;
        end else if (out_valid) begin
          check($sformatf("D_W=%0d mul_r_stable", DW), mul_r, held);
        end
        prev      = out_valid;
        out_ready = (or_mode == 2) ? 1'b1 :
                    (or_mode == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
    end

    // Driver
    initial begin
      int t;
      int len;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      op_a     = '0;
      op_b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("D_W=%0d rst in_ready", DW), in_ready, 1'b0);
      check($sformatf("D_W=%0d rst out_valid", DW), out_valid, 1'b0);
      check($sformatf("D_W=%0d rst mul_r", DW), mul_r, '0);
      rst = 1'b0;
      #1;
      check($sformatf("D_W=%0d post_rst in_ready", DW), in_ready, 1'b1);

      // Directed single operations
      send(A1, B1, 1'b1, 1'b1);
      wait_idle("pass_through");
      send(64'h1, B2, 1'b1, 1'b1);
      send(64'h0, rnd_b(), 1'b1, 1'b1);
      wait_idle("unit_zero");

      // Accumulation: odd repeat count leaves P, even repeat count cancels
      send(A1, B1, 1'b0, 1'b1);
      send(A1, B1, 1'b0, 1'b1);
      send(A1, B1, 1'b1, 1'b1);
      send(A1, B1, 1'b0, 1'b1);
      send(A1, B1, 1'b1, 1'b1);
      wait_idle("accum");

      // Backpressure in DONE, including an in_valid pulse that must be ignored
      or_mode = 1;
      send(A1, B1, 1'b1, 1'b1);
      t = 0;
      while (!out_valid && t < LIM) begin
        @(posedge clk); #1;
        t++;
      end
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        check($sformatf("D_W=%0d bp out_valid", DW), out_valid, 1'b1);
        check($sformatf("D_W=%0d bp in_ready", DW), in_ready, 1'b0);
        in_valid = (c == 3);
        op_a     = 64'h1;
        op_b     = B2;
        in_last  = 1'b1;
      end
      or_mode = 2;
      t = 0;
      while (out_valid && t < LIM) begin
        @(posedge clk); #1;
        t++;
      end
      check($sformatf("D_W=%0d bp release in_ready", DW), in_ready, 1'b1);
      send(64'h1, B2, 1'b1, 1'b1);
      wait_idle("bp_next_chain");

      // Reset while BUSY discards the operation; the next beat sees a clean accumulator
      send(A1, B1, 1'b1, 1'b0);
      repeat (RST_OFS - 1) begin
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check($sformatf("D_W=%0d midrst out_valid", DW), out_valid, 1'b0);
      check($sformatf("D_W=%0d midrst mul_r", DW), mul_r, '0);
      check($sformatf("D_W=%0d midrst in_ready", DW), in_ready, 1'b1);
      send(A1 | 64'h5, B1 ^ B2, 1'b1, 1'b1);
      wait_idle("post_midrst");

      // Random chains with input gaps and random out_ready
      or_mode = 0;
      for (int ch = 0; ch < 250; ch++) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send(rnd_a(), rnd_b(), k == len - 1, 1'b1);
        end
      end
      or_mode = 2;
      wait_idle("random");
      done = 1'b1;
    end
  end

  initial begin
    wait (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: got no completion, want all drivers done");
    $fatal(1);
  end

endmodule

// File: doc/clmul_dser.md
# clmul_dser

Digit-serial GF(2) (carry-less) word multiplier with cross-operation accumulation and valid/ready handshakes on both sides. Computes the same 64×127 windowed partial-product XOR as the single-cycle block multiplier in the key-generation datapath, but consumes D_W bits of op_a per cycle. Multiple operations can be XOR-chained into one result word. Sits between the sparse-row address sequencer and the result-word write-back of the polynomial multiply engine. Area is traded against latency through D_W.

## Interface
- G_DAT_W, 64: word width W of op_a and of mul_r.
- D_W, 16: digit width, meaning op_a bits processed per cycle. Must divide G_DAT_W; elaboration error otherwise.
- N (localparam), G_DAT_W/D_W: cycles per operation.
- CNT_W (localparam), max(1, clog2(N)): digit counter width.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  this operation closes the accumulation chain.
- op_a  in  G_DAT_W  multiplier word.
- op_b  in  2*G_DAT_W-1  multiplicand window.
- out_valid  out  1  mul_r holds a completed chain result.
- out_ready  in  1  consumer accepts the result.
- mul_r  out  G_DAT_W  registered result.

## Operation
- Function of one operation, for i in 0..W-1: P[i] = XOR over j=0..W-1 of (op_a[W-1-j] & op_b[i+j]).
- Chain result: the XOR of P over every operation from the first beat after reset or after the previous output handshake, up to and including the beat with in_last=1.
- Digit c (c=0..N-1) covers j = c*D_W .. c*D_W+D_W-1. Digits are processed in ascending c. The digit partial product is XORed into acc[W-1:0].
- Accepted op_a, op_b and in_last are captured into registers. Inputs may change after the handshake.
- FSM states:
  - IDLE: in_ready=1. On in_valid: capture, cnt<=0, go BUSY.
  - BUSY: each cycle acc<=acc^digit(cnt) and cnt<=cnt+1. On cnt==N-1: if last, go DONE and load mul_r<=final acc. Otherwise go IDLE with acc retained.
  - DONE: out_valid=1 and mul_r held stable. On out_ready: acc<=0, go IDLE.
- in_ready = (state==IDLE) & ~rst. No beat is accepted in BUSY or DONE.
- The counter wraps only through the state transition; cnt is never read outside BUSY.
- Reset in any state: state<=IDLE, acc<=0, cnt<=0, mul_r<=0, out_valid<=0. An operation or chain in flight is discarded with no output.
- Reset values: in_ready=0 while rst is high and 1 on the first cycle after, out_valid=0, mul_r=0.

## Timing
- Acceptance edge E: in_valid & in_ready sampled high.
- BUSY occupies the N edges E+1..E+N. For a last beat, out_valid and mul_r become valid after edge E+N. With D_W=G_DAT_W this is one cycle, the same as the single-cycle multiplier.
- For a non-last beat, in_ready returns high after edge E+N. The next beat can be accepted at edge E+N+1.
- Throughput is one operation per N+1 cycles without backpressure.
- Output handshake at edge H (out_valid & out_ready). in_ready is high after H. The first beat of the next chain is accepted no earlier than H+1.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- mul_r only changes on the DONE entry edge and on reset.

## Test plan
- Config W=64, D_W=16. op_a=64'h8000_0000_0000_0000, op_b[63:0]=64'h0123_4567_89AB_CDEF with upper bits 0, in_last=1 -> out_valid rises 4 edges after acceptance with mul_r=64'h0123_4567_89AB_CDEF.
- op_a=64'h1, op_b=127'h1<<63, in_last=1 -> mul_r=64'h1. Then op_a=64'h0, any op_b -> mul_r=0.
- Accumulation: the first vector issued three times with in_last=0,0,1 -> exactly one out_valid, mul_r=64'h0123_4567_89AB_CDEF. The same vector twice with in_last=0,1 -> mul_r=0.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1, mul_r stable, in_ready=0, and an in_valid pulse is not accepted. Then out_ready=1 -> in_ready=1 on the next cycle, and the next chain starts from acc=0.
- Reset mid-BUSY (rst high at cnt=2 for 1 cycle) -> out_valid=0 and mul_r=0. A following single last beat gives its standalone P with no residue.
- 1000 random chains of length 1..4 with random in_valid/out_ready gaps, for D_W = 1, 8, 16 and 64 -> every mul_r matches the bit-level reference model. Latency is exactly N edges per beat.
